dmem_ctrl: RTL and testbench

Data-memory access controller between the core's MEM stage and the single-port, single-write-enable data BRAM (1-cycle read latency). It sequences core loads and stores, turns byte/halfword stores into a two-cycle read-modify-write, places sub-word data on the correct byte lane, and formats load data with sign or zero extension. It also arbitrates the BRAM between the core and an auxiliary word-access port (program loader / debug) with bounded starvation, and it stalls the core while an access is in flight.

---
 rtl/dmem_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: sequences core loads/stores (with sub-word
// read-modify-write) and an auxiliary word port onto a single-port data BRAM.
package dmem_pkg;
  typedef enum logic [2:0] {
    DATATYPE_BYTE  = 3'd0,
    DATATYPE_HALF  = 3'd1,
    DATATYPE_WORD  = 3'd2,
    DATATYPE_UBYTE = 3'd3,
    DATATYPE_UHALF = 3'd4
  } data_type_bus;
endpackage

// Handshakes: a requester holds req and all its inputs until it sees
// core_ready_o / aux_gnt_o high in a cycle; that cycle completes (or accepts)
// the access and the requester may change its inputs after the clock edge.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned AUX_MAX_WAIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         core_req_i,
  input  logic         core_we_i,
  input  logic [31:0]  core_addr_i,
  input  logic [31:0]  core_wdata_i,
  input  data_type_bus core_type_i,
  output logic [31:0]  core_rdata_o,
  output logic         core_ready_o,
  output logic         core_stall_o,
  output logic         misalign_o,
  input  logic         aux_req_i,
  input  logic         aux_we_i,
  input  logic [31:0]  aux_addr_i,
  input  logic [31:0]  aux_wdata_i,
  output logic         aux_gnt_o,
  output logic         aux_rvalid_o,
  output logic [31:0]  aux_rdata_o,
  output logic         bram_en_o,
  output logic         bram_we_o,
  output logic [29:0]  bram_addr_o,
  output logic [31:0]  bram_wdata_o,
  input  logic [31:0]  bram_rdata_i,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_LD, S_RMW, S_AUX_RD} state_t;

  state_t       state_q, state_d;
  logic [3:0]   wait_q, wait_d;
  logic [29:0]  addr_q;
  data_type_bus type_q;
  logic [1:0]   off_q;
  logic [31:0]  wdata_q;
  logic         lat_en;
  logic         wait_max, aux_win, core_acc, aux_acc, core_misal;
  logic         unused_aux_low;

  assign unused_aux_low = ^aux_addr_i[1:0];
  assign dbg_state      = state_q;

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                           input data_type_bus t);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (t)
      DATATYPE_BYTE:  fmt_load = {{24{b[7]}}, b};
      DATATYPE_UBYTE: fmt_load = {24'd0, b};
      DATATYPE_HALF:  fmt_load = {{16{h[15]}}, h};
      DATATYPE_UHALF: fmt_load = {16'd0, h};
      default:        fmt_load = w;
    endcase
  endfunction

  // A u-type store is treated as the signed type of the same width.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                        input logic [1:0] off, input data_type_bus t);
    merge = w;
    case (t)
      DATATYPE_BYTE, DATATYPE_UBYTE: merge[{off, 3'b000} +: 8] = d[7:0];
      DATATYPE_HALF, DATATYPE_UHALF: begin
        if (off[1]) merge[31:16] = d[15:0];
        else        merge[15:0]  = d[15:0];
      end
      default: merge = d;
    endcase
  endfunction

  always_comb begin
    wait_max = (wait_q == 4'(AUX_MAX_WAIT));
    aux_win  = aux_req_i && (!core_req_i || wait_max);
    core_acc = (state_q == S_IDLE) && core_req_i && !aux_win;
    aux_acc  = (state_q == S_IDLE) && aux_win;
    case (core_type_i)
      DATATYPE_HALF, DATATYPE_UHALF: core_misal = core_addr_i[0];
      DATATYPE_WORD:                 core_misal = (core_addr_i[1:0] != 2'b00);
      default:                       core_misal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    lat_en       = 1'b0;
    core_rdata_o = '0;
    core_ready_o = 1'b0;
    misalign_o   = 1'b0;
    aux_gnt_o    = 1'b0;
    aux_rvalid_o = 1'b0;
    aux_rdata_o  = '0;
    bram_en_o    = 1'b0;
    bram_we_o    = 1'b0;
    bram_addr_o  = '0;
    bram_wdata_o = '0;
    unique case (state_q)
      S_IDLE: begin
        if (core_acc) begin
          if (core_misal) begin
            misalign_o   = 1'b1;
            core_ready_o = 1'b1;
          end else begin
            bram_en_o   = 1'b1;
            bram_addr_o = core_addr_i[31:2];
            lat_en      = 1'b1;
            if (core_we_i && core_type_i == DATATYPE_WORD) begin
              bram_we_o    = 1'b1;
              bram_wdata_o = core_wdata_i;
              core_ready_o = 1'b1;
            end else if (core_we_i) begin
              state_d = S_RMW;
            end else begin
              state_d = S_LD;
            end
          end
        end else if (aux_acc) begin
          aux_gnt_o    = 1'b1;
          bram_en_o    = 1'b1;
          bram_we_o    = aux_we_i;
          bram_addr_o  = aux_addr_i[31:2];
          bram_wdata_o = aux_wdata_i;
          if (!aux_we_i) state_d = S_AUX_RD;
        end
      end
      S_LD: begin
        core_ready_o = 1'b1;
        core_rdata_o = fmt_load(bram_rdata_i, off_q, type_q);
        state_d      = S_IDLE;
      end
      S_RMW: begin
        bram_en_o    = 1'b1;
        bram_we_o    = 1'b1;
        bram_addr_o  = addr_q;
        bram_wdata_o = merge(bram_rdata_i, wdata_q, off_q, type_q);
        core_ready_o = 1'b1;
        state_d      = S_IDLE;
      end
      S_AUX_RD: begin
        aux_rvalid_o = 1'b1;
        aux_rdata_o  = bram_rdata_i;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Reset abandons any in-flight access: nothing may leave the block.
    if (rst) begin
      core_rdata_o = '0;
      core_ready_o = 1'b0;
      misalign_o   = 1'b0;
      aux_gnt_o    = 1'b0;
      aux_rvalid_o = 1'b0;
      aux_rdata_o  = '0;
      bram_en_o    = 1'b0;
      bram_we_o    = 1'b0;
      bram_addr_o  = '0;
      bram_wdata_o = '0;
    end
    core_stall_o = core_req_i && !core_ready_o && !rst;
  end

  // Saturating at the threshold keeps the compare true while the FSM is busy.
  always_comb begin
    wait_d = wait_q;
    if (aux_gnt_o)                   wait_d = '0;
    else if (aux_req_i && !wait_max) wait_d = wait_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      type_q  <= DATATYPE_BYTE;
      off_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (lat_en) begin
        addr_q  <= core_addr_i[31:2];
        type_q  <= core_type_i;
        off_q   <= core_addr_i[1:0];
        wdata_q <= core_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: BRAM model, reference memory model with expected-response
// queues, a negedge monitor, directed scenarios and a randomized concurrent phase.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic         clk, rst;
  logic         core_req_i, core_we_i;
  logic [31:0]  core_addr_i, core_wdata_i;
  data_type_bus core_type_i;
  logic [31:0]  core_rdata_o;
  logic         core_ready_o, core_stall_o, misalign_o;
  logic         aux_req_i, aux_we_i;
  logic [31:0]  aux_addr_i, aux_wdata_i;
  logic         aux_gnt_o, aux_rvalid_o;
  logic [31:0]  aux_rdata_o;
  logic         bram_en_o, bram_we_o;
  logic [29:0]  bram_addr_o;
  logic [31:0]  bram_wdata_o, bram_rdata_i;
  logic [1:0]   dbg_state;

  logic [31:0] bram_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];
  logic [32:0] core_exp_q[$];
  logic [31:0] aux_exp_q[$];
  int total = 0;
  int bad   = 0;

  dmem_ctrl #(.AUX_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_type_i(core_type_i), .core_rdata_o(core_rdata_o),
    .core_ready_o(core_ready_o), .core_stall_o(core_stall_o), .misalign_o(misalign_o),
    .aux_req_i(aux_req_i), .aux_we_i(aux_we_i), .aux_addr_i(aux_addr_i),
    .aux_wdata_i(aux_wdata_i), .aux_gnt_o(aux_gnt_o), .aux_rvalid_o(aux_rvalid_o),
    .aux_rdata_o(aux_rdata_o), .bram_en_o(bram_en_o), .bram_we_o(bram_we_o),
    .bram_addr_o(bram_addr_o), .bram_wdata_o(bram_wdata_o), .bram_rdata_i(bram_rdata_i),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // BRAM with one-cycle read latency
  always @(posedge clk) begin
    if (bram_en_o) begin
      if (bram_we_o) bram_mem[bram_addr_o[9:0]] <= bram_wdata_o;
      else           bram_rdata_i <= bram_mem[bram_addr_o[9:0]];
    end
  end

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{core_rdata_o, core_ready_o, core_stall_o, misalign_o, aux_gnt_o,
             aux_rvalid_o, aux_rdata_o, bram_en_o, bram_we_o, bram_addr_o, bram_wdata_o};
  endfunction

  // reference model: word memory plus load/store rules
  task automatic model_core(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input data_type_bus typ);
    logic [31:0] w, d, mask;
    int sh, idx;
    logic mis;
    idx = int'(addr[11:2]);
    sh  = 8 * int'(addr[1:0]);
    mis = ((typ == DATATYPE_HALF || typ == DATATYPE_UHALF) && addr[0]) ||
          (typ == DATATYPE_WORD && addr[1:0] != 2'b00);
    w = ref_mem[idx];
    if (mis) begin
      core_exp_q.push_back({1'b1, 32'd0});
    end else if (!we) begin
      case (typ)
        DATATYPE_BYTE:  begin d = (w >> sh) & 32'hFF;   if (d >= 32'd128)   d = d | 32'hFFFFFF00; end
        DATATYPE_UBYTE: d = (w >> sh) & 32'hFF;
        DATATYPE_HALF:  begin d = (w >> sh) & 32'hFFFF; if (d >= 32'd32768) d = d | 32'hFFFF0000; end
        DATATYPE_UHALF: d = (w >> sh) & 32'hFFFF;
        default:        d = w;
      endcase
      core_exp_q.push_back({1'b0, d});
    end else begin
      if (typ == DATATYPE_WORD) begin
        ref_mem[idx] = wdata;
      end else begin
        mask = (typ == DATATYPE_BYTE || typ == DATATYPE_UBYTE) ? 32'hFF : 32'hFFFF;
        ref_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
      end
      core_exp_q.push_back({1'b0, 32'd0});
    end
  endtask

  // driver tasks: start and end at posedge+1
  task automatic core_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input data_type_bus typ, output int lat, output logic first_en,
                             output logic first_we);
    model_core(we, addr, wdata, typ);
    core_req_i = 1'b1; core_we_i = we; core_addr_i = addr;
    core_wdata_i = wdata; core_type_i = typ;
    lat = 0; first_en = 1'b0; first_we = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) begin first_en = bram_en_o; first_we = bram_we_o; end
      if (core_ready_o) begin lat = i; break; end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL core_timeout: got no ready expected ready within 100 cycles");
    end
    @(posedge clk); #1;
    core_req_i = 1'b0;
  endtask

  task automatic aux_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic stall_at_gnt);
    if (we) ref_mem[int'(addr[11:2])] = wdata;
    else    aux_exp_q.push_back(ref_mem[int'(addr[11:2])]);
    aux_req_i = 1'b1; aux_we_i = we; aux_addr_i = addr; aux_wdata_i = wdata;
    lat = 0; stall_at_gnt = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (aux_gnt_o) begin lat = i; stall_at_gnt = core_stall_o; break; end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL aux_timeout: got no grant expected grant within 100 cycles");
    end
    @(posedge clk); #1;
    aux_req_i = 1'b0;
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] ce;
    logic [31:0] ae;
    check("stall", {32'd0, core_stall_o}, rst ? 33'd0 : {32'd0, core_req_i & ~core_ready_o});
    if (core_ready_o) begin
      if (core_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL core_unexpected: got ready expected none");
      end else begin
        ce = core_exp_q.pop_front();
        check("core_resp", {misalign_o, core_rdata_o}, ce);
      end
    end else begin
      check("core_quiet", {misalign_o, core_rdata_o}, 33'd0);
    end
    if (aux_rvalid_o) begin
      if (aux_exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL aux_unexpected: got rvalid expected none");
      end else begin
        ae = aux_exp_q.pop_front();
        check("aux_rdata", {1'b0, aux_rdata_o}, {1'b0, ae});
      end
    end else begin
      check("aux_quiet", {1'b0, aux_rdata_o}, 33'd0);
    end
  end

  initial begin
    int lat, la, lc;
    logic en, we, st, e1, w1;
    logic [31:0] v;
    rst = 1'b1;
    core_req_i = 1'b1; core_we_i = 1'b0; core_addr_i = 32'h100; core_wdata_i = '0;
    core_type_i = DATATYPE_WORD;
    aux_req_i = 1'b1; aux_we_i = 1'b0; aux_addr_i = 32'h800; aux_wdata_i = '0;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      bram_mem[i] <= v;
      ref_mem[i] = v;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {32'd0, any_out()}, 33'd0);
    @(posedge clk); #1;
    rst = 1'b0; core_req_i = 1'b0; aux_req_i = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", {32'd0, any_out()}, 33'd0);
    check("post_reset_state", {31'd0, dbg_state}, 33'd0);
    @(posedge clk); #1;

    // word store then load
    core_access(1'b1, 32'h100, 32'hDEADBEEF, DATATYPE_WORD, lat, en, we);
    check("wst_latency", lat, 1);
    check("wst_we_at_accept", {31'd0, en, we}, 33'd3);
    core_access(1'b0, 32'h100, 32'h0, DATATYPE_WORD, lat, en, we);
    check("ld_latency", lat, 2);
    check("ld_read_at_accept", {31'd0, en, we}, 33'd2);

    // sub-word read-modify-write and load formatting
    core_access(1'b1, 32'h200, 32'h11223344, DATATYPE_WORD, lat, en, we);
    core_access(1'b1, 32'h202, 32'h123456AA, DATATYPE_BYTE, lat, en, we);
    check("rmw_latency", lat, 2);
    check("rmw_read_at_accept", {31'd0, en, we}, 33'd2);
    core_access(1'b0, 32'h200, 32'h0, DATATYPE_WORD,  lat, en, we);
    core_access(1'b0, 32'h202, 32'h0, DATATYPE_BYTE,  lat, en, we);
    core_access(1'b0, 32'h202, 32'h0, DATATYPE_UBYTE, lat, en, we);
    core_access(1'b0, 32'h202, 32'h0, DATATYPE_HALF,  lat, en, we);
    core_access(1'b1, 32'h200, 32'h0000BEEF, DATATYPE_HALF, lat, en, we);
    core_access(1'b0, 32'h200, 32'h0, DATATYPE_HALF,  lat, en, we);
    core_access(1'b0, 32'h200, 32'h0, DATATYPE_UHALF, lat, en, we);

    // misaligned accesses
    core_access(1'b0, 32'h201, 32'h0, DATATYPE_HALF, lat, en, we);
    check("mis_half_latency", lat, 1);
    check("mis_half_no_bram", {32'd0, en}, 33'd0);
    core_access(1'b0, 32'h102, 32'h0, DATATYPE_WORD, lat, en, we);
    check("mis_word_no_bram", {32'd0, en}, 33'd0);
    core_access(1'b1, 32'h103, 32'hFFFF, DATATYPE_UHALF, lat, en, we);
    check("mis_store_no_bram", {32'd0, en}, 33'd0);

    // aux read with idle core
    aux_access(1'b0, 32'h100, 32'h0, la, st);
    check("aux_rd_grant_latency", la, 1);
    idle(2);

    // starvation bound, twice (the second run needs wait_cnt cleared)
    for (int r = 0; r < 2; r++) begin
      fork
        begin
          aux_access(1'b0, 32'h103, 32'h0, la, st);
        end
        begin
          for (int k = 0; k < 3; k++) core_access(1'b0, 32'h100, 32'h0, DATATYPE_WORD, lc, e1, w1);
        end
      join
      check("starve_grant_cycle", la, 5);
      check("starve_core_stalled", {32'd0, st}, 33'd1);
      idle(2);
    end

    // reset in the RMW cycle
    core_access(1'b1, 32'h200, 32'h11223344, DATATYPE_WORD, lat, en, we);
    core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 32'h202;
    core_wdata_i = 32'h55; core_type_i = DATATYPE_BYTE;
    @(negedge clk);
    check("rst_rmw_accept_read", {31'd0, bram_en_o, bram_we_o}, 33'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_rmw_no_write", {32'd0, bram_we_o}, 33'd0);
    check("rst_rmw_outputs", {32'd0, any_out()}, 33'd0);
    @(posedge clk); #1;
    rst = 1'b0; core_req_i = 1'b0;
    @(negedge clk);
    check("rst_rmw_state_idle", {31'd0, dbg_state}, 33'd0);
    check("rst_rmw_quiet", {32'd0, any_out()}, 33'd0);
    @(posedge clk); #1;
    core_access(1'b0, 32'h200, 32'h0, DATATYPE_WORD, lat, en, we);

    // randomized concurrent traffic on disjoint regions
    fork
      begin
        int l; logic a, b, cw;
        data_type_bus t;
        for (int k = 0; k < 150; k++) begin
          t  = data_type_bus'($urandom_range(0, 4));
          cw = (t == DATATYPE_UBYTE || t == DATATYPE_UHALF) ? 1'b0 : 1'($urandom_range(0, 1));
          core_access(cw, {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3))},
                      $urandom, t, l, a, b);
          idle($urandom_range(0, 2));
        end
      end
      begin
        int l; logic s;
        for (int k = 0; k < 100; k++) begin
          aux_access(1'($urandom_range(0, 1)),
                     32'h800 | {23'd0, 7'($urandom_range(0, 127)), 2'($urandom_range(0, 3))},
                     $urandom, l, s);
          check("aux_wait_bound", {32'd0, (l >= 1 && l <= 6)}, 33'd1);
          idle($urandom_range(0, 3));
        end
      end
    join
    // read back both regions through the opposite-free path
    for (int k = 0; k < 16; k++) begin
      core_access(1'b0, {20'd0, 8'($urandom_range(0, 127)), 2'b00}, 32'h0, DATATYPE_WORD,
                  lat, en, we);
      aux_access(1'b0, 32'h800 | {23'd0, 7'($urandom_range(0, 127)), 2'b00}, 32'h0, la, st);
    end
    idle(4);
    check("core_queue_drained", core_exp_q.size(), 0);
    check("aux_queue_drained", aux_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
